// File: rtl/rgmii_rx_decode.sv
// RGMII receive decode: turns DDR sample pairs into a GMII byte stream with a clock-enable
// strobe, assembling nibbles at 10/100 and filtering in-band link status during idle.
module rgmii_rx_decode #(
    parameter int STATUS_FILTER = 4,
    parameter bit ENABLE_INBAND = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rgmii_q1,
    input  logic [4:0] rgmii_q2,
    input  logic [1:0] speed,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_ce,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_full_duplex
);
    typedef enum logic [1:0] {IDLE = 2'd0, NIB_HI = 2'd1, NIB_LO = 2'd2} state_t;
    localparam logic [3:0] FILT = 4'(STATUS_FILTER);

    state_t     state;
    logic [1:0] mode_q, mode_eff;
    logic       toggle, seen_idle, lo_er;
    logic [3:0] lo_nib, cand, cnt, cnt_nxt;
    logic       dv, er, is_1g, match;

    assign dv = rgmii_q1[4];
    assign er = rgmii_q1[4] ^ rgmii_q2[4];

    // Speed is only taken on idle cycles, or while still skipping the tail of a frame
    // that was cut by reset, so a frame always finishes in the mode it started in.
    always_comb begin
        mode_eff = mode_q;
        if (state == IDLE && (!dv || !seen_idle))
            mode_eff = speed;
    end
    assign is_1g = mode_eff[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= 2'b10;
            toggle     <= 1'b0;
            seen_idle  <= 1'b0;
            lo_nib     <= 4'h0;
            lo_er      <= 1'b0;
            gmii_rxd   <= 8'h00;
            gmii_rx_dv <= 1'b0;
            gmii_rx_er <= 1'b0;
            gmii_rx_ce <= 1'b0;
        end else begin
            mode_q <= mode_eff;
            if (!dv)
                seen_idle <= 1'b1;
            if (is_1g) begin
                gmii_rxd   <= {rgmii_q2[3:0], rgmii_q1[3:0]};
                gmii_rx_dv <= dv;
                gmii_rx_er <= er;
                gmii_rx_ce <= 1'b1;
                toggle     <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (dv && seen_idle) begin
                            lo_nib     <= rgmii_q1[3:0];
                            lo_er      <= er;
                            gmii_rx_ce <= 1'b0;
                            state      <= NIB_HI;
                        end else begin
                            gmii_rxd   <= 8'h00;
                            gmii_rx_dv <= 1'b0;
                            gmii_rx_er <= 1'b0;
                            gmii_rx_ce <= toggle;
                            toggle     <= ~toggle;
                        end
                    end
                    NIB_HI: begin
                        gmii_rx_dv <= 1'b1;
                        gmii_rx_ce <= 1'b1;
                        if (dv) begin
                            gmii_rxd   <= {rgmii_q1[3:0], lo_nib};
                            gmii_rx_er <= lo_er | er;
                            state      <= NIB_LO;
                        end else begin
                            // Odd nibble count: flush the half byte as an errored byte.
                            gmii_rxd   <= {4'h0, lo_nib};
                            gmii_rx_er <= 1'b1;
                            toggle     <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    NIB_LO: begin
                        gmii_rx_ce <= 1'b0;
                        if (dv) begin
                            lo_nib <= rgmii_q1[3:0];
                            lo_er  <= er;
                            state  <= NIB_HI;
                        end else begin
                            // The end-of-frame dv=0 strobe comes from IDLE next cycle,
                            // keeping strobes at least two cycles apart.
                            gmii_rx_dv <= 1'b0;
                            gmii_rx_er <= 1'b0;
                            toggle     <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        match   = (cnt != 4'd0) && (rgmii_q1[3:0] == cand);
        cnt_nxt = 4'd1;
        if (match)
            cnt_nxt = (cnt >= FILT) ? cnt : cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand             <= 4'h0;
            cnt              <= 4'd0;
            link_up          <= 1'b0;
            link_speed       <= 2'b00;
            link_full_duplex <= 1'b0;
        end else if (ENABLE_INBAND) begin
            if (dv || er) begin
                cnt <= 4'd0;
            end else begin
                cnt <= cnt_nxt;
                if (!match)
                    cand <= rgmii_q1[3:0];
                if (cnt_nxt == FILT) begin
                    link_up          <= rgmii_q1[0];
                    link_speed       <= rgmii_q1[2:1];
                    link_full_duplex <= rgmii_q1[3];
                end
            end
        end
    end
endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Randomized bench for rgmii_rx_decode: frame-level byte model for nibble mode,
// per-cycle pass-through model for 1G, run-length model for in-band status.
module tb_rgmii_rx_decode;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] q1 = 5'h00, q2 = 5'h00;
    logic [1:0] speed = 2'b10;
    logic [7:0] rxd;
    logic       rx_dv, rx_er, rx_ce, link_up, link_full_duplex;
    logic [1:0] link_speed;

    int checks = 0;
    int errors = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    bit         collect = 1'b0;
    bit         nib_mode = 1'b0;
    bit         prev_ce = 1'b0;
    int         consec = 0;

    rgmii_rx_decode #(.STATUS_FILTER(4), .ENABLE_INBAND(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rgmii_q1(q1), .rgmii_q2(q2), .speed(speed),
        .gmii_rxd(rxd), .gmii_rx_dv(rx_dv), .gmii_rx_er(rx_er), .gmii_rx_ce(rx_ce),
        .link_up(link_up), .link_speed(link_speed), .link_full_duplex(link_full_duplex)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (collect && rx_ce && rx_dv)
            got_q.push_back({rx_er, rxd});
        if (nib_mode && rx_ce && prev_ce)
            consec++;
        prev_ce = rx_ce;
    end

    task automatic step(input logic [4:0] a, input logic [4:0] b);
        q1 = a;
        q2 = b;
        @(posedge clk);
        #1;
    endtask

    // Drives one nibble-mode frame and appends the bytes it should produce to exp_q.
    task automatic send_frame(input int len, input bit allow_err);
        logic [3:0] nib[16];
        bit         e[16];
        logic [3:0] r;
        for (int k = 0; k < len; k++) begin
            r = 4'($urandom);
            nib[k] = r;
            e[k] = allow_err && ($urandom_range(0, 5) == 0);
            step({1'b1, r}, {~e[k], r});
        end
        for (int k = 0; k < len; k += 2) begin
            if (k + 1 < len) exp_q.push_back({e[k] | e[k+1], nib[k+1], nib[k]});
            else             exp_q.push_back({1'b1, 4'h0, nib[k]});
        end
    endtask

    task automatic compare_queues(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s byte count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s byte %0d: got er/rxd %h expected %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (consec != 0) begin
            errors++;
            $display("FAIL %s ce on consecutive cycles: got %0d expected 0", name, consec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        speed = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rxd, rx_dv, rx_er, rx_ce, link_up, link_speed, link_full_duplex} !== 14'h0) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0",
                     {rxd, rx_dv, rx_er, rx_ce, link_up, link_speed, link_full_duplex});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_1g();
        logic [4:0] a, b;
        speed = 2'b10;
        step(5'h00, 5'h00);
        for (int i = 0; i < 8; i++) begin
            step(5'h15, 5'h15);
            checks++;
            if ({rxd, rx_dv, rx_er, rx_ce} !== {8'h55, 3'b101}) begin
                errors++;
                $display("FAIL 1g preamble %0d: got %h/%b%b%b expected 55/101", i, rxd, rx_dv, rx_er, rx_ce);
            end
        end
        step(5'h00, 5'h00);
        checks++;
        if (rx_dv !== 1'b0 || rx_ce !== 1'b1) begin
            errors++;
            $display("FAIL 1g dv drop: got dv=%b ce=%b expected dv=0 ce=1", rx_dv, rx_ce);
        end
        for (int i = 0; i < 40; i++) begin
            a = 5'($urandom);
            b = 5'($urandom);
            step(a, b);
            checks++;
            if ({rxd, rx_dv, rx_er, rx_ce} !== {b[3:0], a[3:0], a[4], a[4] ^ b[4], 1'b1}) begin
                errors++;
                $display("FAIL 1g random %0d: got %h/%b%b%b expected %h/%b%b1", i, rxd, rx_dv, rx_er, rx_ce,
                         {b[3:0], a[3:0]}, a[4], a[4] ^ b[4]);
            end
        end
        step(5'h00, 5'h00);
    endtask

    task automatic test_100m_fixed();
        speed = 2'b01;
        repeat (4) step(5'h00, 5'h00);
        nib_mode = 1'b1;
        consec = 0;
        step(5'h15, 5'h15);
        checks++;
        if (rx_ce !== 1'b0) begin errors++; $display("FAIL 100m first nibble ce: got %b expected 0", rx_ce); end
        step(5'h15, 5'h15);
        checks++;
        if ({rx_ce, rx_dv, rx_er, rxd} !== {3'b110, 8'h55}) begin
            errors++;
            $display("FAIL 100m byte0: got ce/dv/er %b%b%b rxd %h expected 110 55", rx_ce, rx_dv, rx_er, rxd);
        end
        step(5'h15, 5'h15);
        checks++;
        if (rx_ce !== 1'b0) begin errors++; $display("FAIL 100m third nibble ce: got %b expected 0", rx_ce); end
        step(5'h1D, 5'h1D);
        checks++;
        if ({rx_ce, rx_dv, rx_er, rxd} !== {3'b110, 8'hD5}) begin
            errors++;
            $display("FAIL 100m byte1: got ce/dv/er %b%b%b rxd %h expected 110 d5", rx_ce, rx_dv, rx_er, rxd);
        end
        step(5'h00, 5'h00);
        checks++;
        if (rx_ce !== 1'b0) begin errors++; $display("FAIL 100m after frame ce: got %b expected 0", rx_ce); end
        repeat (2) step(5'h00, 5'h00);
        step(5'h11, 5'h11);
        step(5'h12, 5'h12);
        checks++;
        if ({rx_ce, rx_dv, rx_er, rxd} !== {3'b110, 8'h21}) begin
            errors++;
            $display("FAIL 100m odd byte0: got ce/dv/er %b%b%b rxd %h expected 110 21", rx_ce, rx_dv, rx_er, rxd);
        end
        step(5'h13, 5'h13);
        step(5'h00, 5'h00);
        checks++;
        if ({rx_ce, rx_dv, rx_er, rxd} !== {3'b111, 8'h03}) begin
            errors++;
            $display("FAIL 100m odd tail: got ce/dv/er %b%b%b rxd %h expected 111 03", rx_ce, rx_dv, rx_er, rxd);
        end
        step(5'h00, 5'h00);
        checks++;
        if (rx_ce !== 1'b0) begin errors++; $display("FAIL 100m odd tail ce spacing: got %b expected 0", rx_ce); end
        step(5'h00, 5'h00);
        checks++;
        if (consec != 0) begin errors++; $display("FAIL 100m fixed consecutive ce: got %0d expected 0", consec); end
    endtask

    task automatic test_nibble_random();
        got_q.delete();
        exp_q.delete();
        consec = 0;
        collect = 1'b1;
        for (int f = 0; f < 12; f++) begin
            speed = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
            repeat ($urandom_range(2, 4)) step(5'h00, 5'h00);
            send_frame($urandom_range(1, 9), 1'b1);
        end
        repeat (3) step(5'h00, 5'h00);
        collect = 1'b0;
        compare_queues("nibble random");
    endtask

    task automatic test_inband();
        logic [3:0] exp_st, last, s;
        logic [4:0] a, b;
        int         run;
        nib_mode = 1'b0;
        speed = 2'b10;
        repeat (2) step(5'h00, 5'h00);
        for (int i = 0; i < 3; i++) begin
            step(5'h0D, 5'h0D);
            checks++;
            if ({link_full_duplex, link_speed, link_up} !== 4'h0) begin
                errors++;
                $display("FAIL inband early %0d: got %h expected 0", i, {link_full_duplex, link_speed, link_up});
            end
        end
        step(5'h0C, 5'h0C);
        for (int i = 0; i < 3; i++) begin
            step(5'h0D, 5'h0D);
            checks++;
            if ({link_full_duplex, link_speed, link_up} !== 4'h0) begin
                errors++;
                $display("FAIL inband restart %0d: got %h expected 0", i, {link_full_duplex, link_speed, link_up});
            end
        end
        step(5'h0D, 5'h0D);
        checks++;
        if ({link_up, link_speed, link_full_duplex} !== 4'b1101) begin
            errors++;
            $display("FAIL inband update: got link=%b speed=%b fd=%b expected 1 10 1", link_up, link_speed, link_full_duplex);
        end
        exp_st = 4'hD;
        last = 4'hD;
        run = 4;
        s = 4'hD;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0: begin a = {1'b1, 4'($urandom)}; b = a; end
                1: begin a = {1'b0, 4'($urandom)}; b = {1'b1, a[3:0]}; end
                default: begin
                    if ($urandom_range(0, 4) == 0) s = 4'($urandom);
                    a = {1'b0, s};
                    b = a;
                end
            endcase
            step(a, b);
            if (a[4] || b[4]) run = 0;
            else if (run > 0 && a[3:0] == last) run++;
            else begin run = 1; last = a[3:0]; end
            if (run >= 4) exp_st = last;
            checks++;
            if ({link_full_duplex, link_speed, link_up} !== exp_st) begin
                errors++;
                $display("FAIL inband random %0d: got %h expected %h", i, {link_full_duplex, link_speed, link_up}, exp_st);
            end
        end
        step(5'h00, 5'h00);
    endtask

    task automatic test_speed_switch();
        logic [4:0] a, b;
        nib_mode = 1'b0;
        speed = 2'b10;
        repeat (2) step(5'h00, 5'h00);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) speed = 2'b01;
            a = {1'b1, 4'($urandom)};
            b = {1'b1, 4'($urandom)};
            step(a, b);
            checks++;
            if ({rx_ce, rx_dv, rx_er, rxd} !== {3'b110, b[3:0], a[3:0]}) begin
                errors++;
                $display("FAIL switch 1g byte %0d: got ce/dv/er %b%b%b rxd %h expected 110 %h", i, rx_ce, rx_dv,
                         rx_er, rxd, {b[3:0], a[3:0]});
            end
        end
        step(5'h00, 5'h00);
        checks++;
        if (rx_dv !== 1'b0) begin errors++; $display("FAIL switch frame end dv: got %b expected 0", rx_dv); end
        repeat (2) step(5'h00, 5'h00);
        nib_mode = 1'b1;
        consec = 0;
        got_q.delete();
        exp_q.delete();
        collect = 1'b1;
        send_frame(4, 1'b0);
        repeat (3) step(5'h00, 5'h00);
        collect = 1'b0;
        compare_queues("switch nibble");
    endtask

    task automatic test_reset_midframe();
        speed = 2'b01;
        nib_mode = 1'b1;
        repeat (5) step(5'h0D, 5'h0D);
        step(5'h1A, 5'h1A);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rxd, rx_dv, rx_er, rx_ce, link_up, link_speed, link_full_duplex} !== 14'h0) begin
            errors++;
            $display("FAIL async reset outputs: got %h expected 0",
                     {rxd, rx_dv, rx_er, rx_ce, link_up, link_speed, link_full_duplex});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        consec = 0;
        got_q.delete();
        exp_q.delete();
        collect = 1'b1;
        repeat (3) step(5'h1B, 5'h1B);
        repeat (3) step(5'h00, 5'h00);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL reset tail strobes: got %0d data bytes expected 0", got_q.size());
        end
        send_frame(6, 1'b0);
        repeat (3) step(5'h00, 5'h00);
        collect = 1'b0;
        compare_queues("post reset");
    endtask

    initial begin
        test_reset();
        test_1g();
        test_100m_fixed();
        test_nibble_random();
        test_inband();
        test_speed_switch();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rgmii_rx_decode.md
Name: rgmii_rx_decode

Overview:
- Consumes the rising-edge and falling-edge sample pairs from the RGMII source-synchronous DDR input stage.
- Produces a GMII-style receive byte stream qualified by a clock-enable strobe.
- Handles 1000 Mb/s byte mode and 10/100 Mb/s nibble assembly.
- Extracts RGMII in-band link status during inter-frame idle.
- Sits between the DDR input stage and the MAC receive path, in the recovered RX clock domain.

Parameters:
- STATUS_FILTER, 4: consecutive identical idle in-band status samples required before the status outputs update (1..15).
- ENABLE_INBAND, 1: 1 = decode in-band status; 0 = status outputs held at reset values.

Ports:
- clk  input  1  recovered RX clock (the DDR input stage's output clock)
- rst_n  input  1  asynchronous active-low reset
- rgmii_q1  input  5  rising-edge sample {rx_ctl, rxd[3:0]}
- rgmii_q2  input  5  falling-edge sample {rx_ctl, rxd[3:0]}
- speed  input  2  operating speed: 2'b10 = 1G, 2'b01 = 100M, 2'b00 = 10M (2'b11 is treated as 1G)
- gmii_rxd  output  8  received byte
- gmii_rx_dv  output  1  data valid
- gmii_rx_er  output  1  receive error
- gmii_rx_ce  output  1  strobe: the gmii_* outputs are valid this cycle
- link_up  output  1  in-band link status
- link_speed  output  2  in-band speed, same encoding as speed
- link_full_duplex  output  1  in-band duplex

Behaviour:
- Reset: all outputs 0; state IDLE; filter counter 0; latched speed 2'b10.
- Decode of each input pair:
  - dv = q1[4]
  - er = q1[4] ^ q2[4]
- speed is latched into the internal mode register only in state IDLE. A change on speed mid-frame has no effect until the frame ends.
- 1G mode:
  - gmii_rxd = {q2[3:0], q1[3:0]}, gmii_rx_dv = dv, gmii_rx_er = er.
  - Registered once, so latency is 1 clk.
  - gmii_rx_ce = 1 every cycle.
- 10/100 mode uses states IDLE, NIB_HI, NIB_LO. Only q1 data nibbles are used.
  - IDLE:
    - dv=0: output gmii_rx_dv=0 with gmii_rx_ce pulsed every 2nd cycle; free-running toggle.
    - dv=1 (frame start): store the low nibble and er, go to NIB_HI. No strobe this cycle.
  - NIB_HI:
    - dv=1: output byte {q1[3:0], stored_lo}, with gmii_rx_er = OR of both nibbles' er; gmii_rx_dv=1, gmii_rx_ce=1 next cycle; go to NIB_LO.
    - dv=0 (odd nibble count, frame ended mid-byte): output {4'h0, stored_lo} with gmii_rx_dv=1, gmii_rx_er=1, gmii_rx_ce=1; go to IDLE.
  - NIB_LO:
    - dv=1: store the low nibble, go to NIB_HI.
    - dv=0: go to IDLE; emit a dv=0 strobe.
  - Latency is 1 clk after the high nibble.
  - The first nibble after a dv rise is always the low nibble; byte alignment is re-established on every frame.
- gmii_rx_ce is a single-cycle pulse in 10/100 mode and never asserts on consecutive cycles.
- In-band status:
  - Sampled only when dv=0 and er=0, from q1[3:0]: bit0 = link, bits2:1 = speed, bit3 = duplex.
  - A candidate register holds the last sample. The counter increments while the sample equals the candidate; otherwise the counter resets to 1 and the candidate is reloaded.
  - When the counter reaches STATUS_FILTER, the outputs load the candidate and the counter saturates.
  - Any cycle with dv=1 or er=1 clears the counter to 0 but keeps the outputs.
- Carrier-extend/error idle (dv=0, er=1) in 1G mode passes through as gmii_rx_dv=0, gmii_rx_er=1, gmii_rxd = raw byte.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). After release, decoding restarts in IDLE; the remainder of the frame is ignored until the next dv rise in 10/100 mode. In 1G mode bytes pass through immediately.

Test Plan:
- 1G, speed=2'b10, 8 cycles with q1=5'h15, q2=5'h15 (dv=1) -> one cycle later gmii_rxd=8'h55, dv=1, er=0, ce=1 on every cycle; dv drops 1 clk after q1[4] drops.
- 100M, speed=2'b01, frame nibbles 5,5,5,D (q1=q2 ctl=1) -> exactly two ce pulses, carrying 8'h55 then 8'hD5, dv=1 and er=0 on both, each 1 clk after its high nibble.
- 100M, odd frame of 3 nibbles 1,2,3 -> bytes 8'h21 (er=0), then 8'h03 with er=1 and dv=1; state returns to IDLE.
- 1G, idle q1=q2=5'h0D (link=1, speed=2'b10, duplex=1) held 3 cycles, then 4 more cycles -> status outputs unchanged after 3 cycles; link_up=1, link_speed=2'b10, link_full_duplex=1 after the 4th matching sample; an interleaved 5'h0C sample restarts the count.
- speed toggled 2'b10 -> 2'b01 mid-frame in 1G -> frame completes in byte mode with ce every cycle; the next frame is decoded in nibble mode.
- rst_n pulsed low during NIB_HI -> all outputs 0 asynchronously; no partial-byte strobe after release; the next frame decodes correctly.
